joy_dir_arbiter: RTL and testbench
==================================

Name: joy_dir_arbiter

Overview:
- Parametrised, multi-channel successor to the per-player one-direction joystick filter in the arcade emu tops.
- Takes raw direction bits per player from keyboard or joystick, then applies:
  - optional 90° remap for no-rotate display,
  - a selectable restriction mode (4-way, 8-way, 2-way, passthrough).
- Outputs clean per-player direction vectors plus a change strobe.
- Sits between hps_io/keyboard decode and the core's input registers.

Parameters:
- CHANNELS, 2, number of independent players/sticks.
- DEB_W, 4, debounce counter width; used only with JOYDIR_DEBOUNCE_EN. Stable window is 2^DEB_W clk_sys cycles.

Ports:
- clk_sys  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mode  in  2  00 passthrough, 01 4-way, 10 8-way, 11 2-way (horizontal only). Common to all channels.
- rotate  in  1  1 = remap directions for horizontal (no-rotate) display.
- in_dir  in  4*CHANNELS  raw directions. Channel c occupies [4c+3:4c], bit order {up,down,left,right}; bit 3 = up, bit 0 = right. Active high.
- out_dir  out  4*CHANNELS  filtered directions, same packing.
- dir_chg  out  CHANNELS  one-cycle pulse when that channel's out_dir changes.

Behaviour:
- Reset: on reset_n low, clear out_dir, dir_chg, all sync/history registers and all per-channel current-direction registers (cur) to 0, immediately and asynchronously. Operation resumes on the first clk_sys edge after deassertion.
- Rotate (combinational, before any register):
  - rotate=1: internal {up,down,left,right} = raw {left,right,down,up}.
  - rotate=0: identity.
- Stage 1: in1 <= rotated input; in2 <= in1. Rising edge vector rise = in1 & ~in2, per bit.
- Stage 2, per channel, the next output nxt is chosen by mode:
  - 00: nxt = in1.
  - 10: nxt = in1 with SOCD clear. Up and down both set → both cleared; left and right both set → both cleared.
  - 01 (4-way) updates cur, then nxt = cur. Priority order:
    - rise ≠ 0: cur = highest-index set bit of rise (up > down > left > right).
    - else if cur & in1 ≠ 0: hold cur.
    - else if in1 ≠ 0: fallback, cur = highest-index set bit of in1.
    - else: cur = 0.
  - 11 (2-way): same rules as 01, applied to in1 & 4'b0011 and rise & 4'b0011. Up and down never appear on the output.
- Output: out_dir <= nxt. dir_chg[c] <= (nxt ≠ out_dir[c]), registered in the same cycle as out_dir.
- Latency: without debounce, a change on in_dir at edge t appears on out_dir after edge t+2.
- Mode change mid-operation: cur is cleared in the cycle mode differs from its registered copy. The new mode then takes effect next cycle; 4-way/2-way resolve through the fallback rule with no re-press needed.
- Rotate change: treated as new input. Rising edges created by the remap count as presses.
- Channels are fully independent. No cross-channel interaction.

Optional Feature:
- JOYDIR_DEBOUNCE_EN defined:
  - Each bit of in1 feeds a DEB_W-bit counter.
  - The debounced bit takes the in1 value only after it has been stable and differing from the debounced value for 2^DEB_W consecutive cycles. The counter restarts on any toggle.
  - Debounced bits replace in1 in the rise, hold and output logic; in2 tracks the debounced value.
  - Latency becomes 2 + 2^DEB_W cycles.
  - Counters and debounced bits reset to 0.
- Not defined: no counters are built; debounced = in1.

Test Plan:
- Reset, CHANNELS=2, mode=01: hold reset_n=0 with in_dir=8'hFF → out_dir=0, dir_chg=0. Release → out_dir[3:0]=4'b1000 two cycles later (all four bits rise together; up wins). dir_chg[0] pulses once.
- mode=01, ch0: press right (0001). After 2 cycles add up (1001) → out=1000. Release up (0001) → out falls back to 0001, with no output gap longer than 1 cycle.
- mode=10, ch1: in=4'b1100 → out=0000. Then in=4'b1010 → out=1010. Then in=4'b1111 → out=0000. dir_chg pulses on each change.
- mode=11: in=4'b1001 → out=0001. in=4'b1000 → out=0000 within 2 cycles.
- rotate=1, mode=00: raw in=4'b0010 (left) → out=4'b1000 (up). Raw 4'b0001 (right) → 4'b0100 (down).
- JOYDIR_DEBOUNCE_EN, DEB_W=2:
  - 3-cycle glitch on right → out unchanged.
  - Steady press → out=0001 exactly 6 cycles after the input edge.
  - Assert reset_n mid-count → counters and out return to 0.

Source files
------------

// File: rtl/joy_dir_arbiter.sv
// joy_dir_arbiter: per-player joystick direction filter.
// Raw {up,down,left,right} bits per channel are optionally rotated 90 degrees,
// synchronised, optionally debounced, then restricted according to mode
// (passthrough / 4-way / 8-way with SOCD clear / 2-way horizontal).
// Optional feature macro: JOYDIR_DEBOUNCE_EN (per-bit stable-window debounce).
module joy_dir_arbiter #(
    parameter int CHANNELS = 2,
    parameter int DEB_W    = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic                  rotate,
    input  logic [4*CHANNELS-1:0] in_dir,
    output logic [4*CHANNELS-1:0] out_dir,
    output logic [CHANNELS-1:0]   dir_chg
);

    localparam int NB = 4 * CHANNELS;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_4WAY = 2'b01;
    localparam logic [1:0] MODE_8WAY = 2'b10;
    localparam logic [1:0] MODE_2WAY = 2'b11;

    // One-hot of the highest-priority set bit (up > down > left > right).
    function automatic logic [3:0] top_bit(input logic [3:0] v);
        logic [3:0] r;
        if (v[3]) begin
            r = 4'b1000;
        end else if (v[2]) begin
            r = 4'b0100;
        end else if (v[1]) begin
            r = 4'b0010;
        end else if (v[0]) begin
            r = 4'b0001;
        end else begin
            r = 4'b0000;
        end
        return r;
    endfunction

    // Opposing directions pressed together cancel each other.
    function automatic logic [3:0] socd_clear(input logic [3:0] v);
        logic [3:0] r;
        r[3:2] = (v[3] & v[2]) ? 2'b00 : v[3:2];
        r[1:0] = (v[1] & v[0]) ? 2'b00 : v[1:0];
        return r;
    endfunction

    // Single-direction resolution: newest press wins, a held direction sticks,
    // and releasing it falls back to whatever is still held.
    function automatic logic [3:0] resolve(input logic [3:0] cur,
                                           input logic [3:0] rise,
                                           input logic [3:0] lvl);
        logic [3:0] r;
        if (rise != 4'b0000) begin
            r = top_bit(rise);
        end else if ((cur & lvl) != 4'b0000) begin
            r = cur;
        end else if (lvl != 4'b0000) begin
            r = top_bit(lvl);
        end else begin
            r = 4'b0000;
        end
        return r;
    endfunction

    logic [NB-1:0]       rot_s;
    logic [NB-1:0]       deb_s;
    logic [NB-1:0]       rise_s;
    logic [NB-1:0]       nxt_s;
    logic [NB-1:0]       in1_d, in1_q;
    logic [NB-1:0]       in2_d, in2_q;
    logic [NB-1:0]       cur_d, cur_q;
    logic [NB-1:0]       out_d, out_q;
    logic [CHANNELS-1:0] chg_d, chg_q;
    logic [1:0]          mode_d, mode_q;

    // Rotation remap ahead of any register: {u,d,l,r} <= raw {l,r,d,u}.
    always_comb begin
        rot_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rotate) begin
                rot_s[4*c +: 4] = {in_dir[4*c+1], in_dir[4*c], in_dir[4*c+2], in_dir[4*c+3]};
            end else begin
                rot_s[4*c +: 4] = in_dir[4*c +: 4];
            end
        end
    end

`ifdef JOYDIR_DEBOUNCE_EN
    logic [NB-1:0][DEB_W-1:0] cnt_d, cnt_q;
    logic [NB-1:0]            db_d, db_q;

    // Per-bit debounce: accept a new level only after it has differed from the
    // debounced value for a full 2^DEB_W cycles; any return restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < NB; i++) begin
            if (in1_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == {DEB_W{1'b1}}) begin
                cnt_d[i] = '0;
                db_d[i]  = in1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Debounce counter and debounced-level registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            db_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign deb_s = db_q;
`else
    assign deb_s = in1_q;
`endif

    // Input synchroniser / history and rising-edge detection.
    always_comb begin
        in1_d  = rot_s;
        in2_d  = deb_s;
        rise_s = deb_s & ~in2_q;
    end

    // Per-channel restriction; a mode change flushes the current direction so
    // the new mode re-resolves from the held inputs on the following cycle.
    always_comb begin
        nxt_s  = '0;
        cur_d  = cur_q;
        chg_d  = '0;
        mode_d = mode;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode_q)
                MODE_PASS: begin
                    nxt_s[4*c +: 4] = deb_s[4*c +: 4];
                end
                MODE_8WAY: begin
                    nxt_s[4*c +: 4] = socd_clear(deb_s[4*c +: 4]);
                end
                MODE_4WAY: begin
                    cur_d[4*c +: 4] = resolve(cur_q[4*c +: 4], rise_s[4*c +: 4], deb_s[4*c +: 4]);
                    nxt_s[4*c +: 4] = cur_d[4*c +: 4];
                end
                MODE_2WAY: begin
                    cur_d[4*c +: 4] = resolve(cur_q[4*c +: 4] & 4'b0011,
                                              rise_s[4*c +: 4] & 4'b0011,
                                              deb_s[4*c +: 4] & 4'b0011);
                    nxt_s[4*c +: 4] = cur_d[4*c +: 4];
                end
                default: begin
                    nxt_s[4*c +: 4] = 4'b0000;
                end
            endcase
            if (mode != mode_q) begin
                cur_d[4*c +: 4] = 4'b0000;
            end else begin
                cur_d[4*c +: 4] = cur_d[4*c +: 4];
            end
            chg_d[c] = (nxt_s[4*c +: 4] != out_q[4*c +: 4]);
        end
        out_d = nxt_s;
    end

    // Pipeline, direction state and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in1_q  <= '0;
            in2_q  <= '0;
            cur_q  <= '0;
            out_q  <= '0;
            chg_q  <= '0;
            mode_q <= 2'b00;
        end else begin
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            cur_q  <= cur_d;
            out_q  <= out_d;
            chg_q  <= chg_d;
            mode_q <= mode_d;
        end
    end

    assign out_dir = out_q;
    assign dir_chg = chg_q;

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// Directed self-checking bench for joy_dir_arbiter (default build, CHANNELS=2).
module tb_joy_dir_arbiter;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       rotate;
    logic [7:0] in_dir;
    logic [7:0] out_dir;
    logic [1:0] dir_chg;

    int n_cmp = 0;
    int n_err = 0;

    joy_dir_arbiter #(.CHANNELS(2), .DEB_W(4)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .mode    (mode),
        .rotate  (rotate),
        .in_dir  (in_dir),
        .out_dir (out_dir),
        .dir_chg (dir_chg)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 2'b01;
        rotate  = 1'b0;
        in_dir  = 8'hFF;
        #3;
        chk("rst_out", out_dir, 8'h00);
        chk("rst_chg", {6'd0, dir_chg}, 8'h00);
        tick(3);
        chk("rst_out_hold", out_dir, 8'h00);
        reset_n = 1'b1;
        tick(1);
        chk("rel_e1", out_dir, 8'h00);
        tick(1);
        chk("rel_up_wins", out_dir, 8'h88);
        chk("rel_chg", {6'd0, dir_chg}, 8'h03);
        tick(1);
        chk("rel_chg_once", {6'd0, dir_chg}, 8'h00);

        // 4-way on channel 0
        in_dir = 8'h00; tick(2);
        chk("w4_clear", out_dir, 8'h00);
        in_dir = 8'h01; tick(2);
        chk("w4_right", out_dir, 8'h01);
        chk("w4_right_chg", {6'd0, dir_chg}, 8'h01);
        tick(2);
        chk("w4_hold", out_dir, 8'h01);
        in_dir = 8'h09; tick(1);
        chk("w4_lat", out_dir, 8'h01);
        tick(1);
        chk("w4_up_new", out_dir, 8'h08);
        in_dir = 8'h01; tick(1);
        chk("w4_nogap", out_dir, 8'h08);
        tick(1);
        chk("w4_fallback", out_dir, 8'h01);

        // 8-way on channel 1
        mode = 2'b10; in_dir = 8'h00; tick(3);
        chk("w8_idle", out_dir, 8'h00);
        in_dir = 8'hC0; tick(2);
        chk("w8_ud", out_dir, 8'h00);
        chk("w8_ud_chg", {6'd0, dir_chg}, 8'h00);
        in_dir = 8'hA0; tick(2);
        chk("w8_diag", out_dir, 8'hA0);
        chk("w8_diag_chg", {6'd0, dir_chg}, 8'h02);
        tick(1);
        chk("w8_chg_pulse", {6'd0, dir_chg}, 8'h00);
        in_dir = 8'hF0; tick(2);
        chk("w8_all", out_dir, 8'h00);
        chk("w8_all_chg", {6'd0, dir_chg}, 8'h02);

        // 2-way
        mode = 2'b11; in_dir = 8'h00; tick(3);
        chk("w2_idle", out_dir, 8'h00);
        in_dir = 8'h09; tick(2);
        chk("w2_ur", out_dir, 8'h01);
        in_dir = 8'h08; tick(2);
        chk("w2_up", out_dir, 8'h00);
        in_dir = 8'h99; tick(2);
        chk("w2_both_ch", out_dir, 8'h11);

        // Rotate with passthrough
        mode = 2'b00; rotate = 1'b1; in_dir = 8'h00; tick(3);
        chk("rot_idle", out_dir, 8'h00);
        in_dir = 8'h02; tick(2);
        chk("rot_left_up", out_dir, 8'h08);
        in_dir = 8'h01; tick(2);
        chk("rot_right_down", out_dir, 8'h04);
        in_dir = 8'h40; tick(2);
        chk("rot_ch1_down_left", out_dir, 8'h20);

        // Mode change resolves through fallback without re-press
        rotate = 1'b0; in_dir = 8'h03; tick(3);
        chk("mc_pass", out_dir, 8'h03);
        mode = 2'b01; tick(2);
        chk("mc_fallback", out_dir, 8'h02);

        // Asynchronous reset mid-operation
        #3 reset_n = 1'b0;
        #1;
        chk("arst_out", out_dir, 8'h00);
        chk("arst_chg", {6'd0, dir_chg}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
